// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register behind the ripple-carry add/subtract chain.
// Captures sum, control fields and derived flags, gates the writes of
// trapping overflows, and emits a one-shot overflow exception pulse.
module ex_mem_stage_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_sum,
    input  logic             ex_c_msb,
    input  logic             ex_cout,
    input  logic             ex_sub,
    input  logic             ex_trap_ovf,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [WIDTH-1:0] ex_store_data,
    input  logic             stall,
    input  logic             flush,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_alu_result,
    output logic             mem_zero,
    output logic             mem_ovf,
    output logic             mem_borrow,
    output logic [RA_W-1:0]  mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [WIDTH-1:0] mem_store_data,
    output logic             ovf_exc
);

    typedef enum logic {
        IDLE = 1'b0,
        SENT = 1'b1
    } state_t;

    state_t state;

    logic ovf_c;
    logic zero_c;
    logic borrow_c;
    logic trap_c;
    logic capture_c;

    // Flags from the MSB cell carries and the sum; trap qualifies signed ops.
    always_comb begin
        ovf_c     = ex_c_msb ^ ex_cout;
        zero_c    = (ex_sum == '0);
        borrow_c  = ex_sub & ~ex_cout;
        trap_c    = ex_valid & ex_trap_ovf & ovf_c;
        capture_c = ~flush & ~stall;
    end

    // Pipeline register: flush bubbles, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_zero       <= 1'b0;
            mem_ovf        <= 1'b0;
            mem_borrow     <= 1'b0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_store_data <= '0;
        end else if (flush) begin
            // Data buses deliberately keep their old contents.
            mem_valid     <= 1'b0;
            mem_zero      <= 1'b0;
            mem_ovf       <= 1'b0;
            mem_borrow    <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_alu_result <= ex_sum;
            mem_zero       <= ex_valid & zero_c;
            mem_ovf        <= ex_valid & ovf_c;
            mem_borrow     <= ex_valid & borrow_c;
            mem_rd         <= ex_rd;
            mem_reg_write  <= ex_valid & ex_reg_write & ~trap_c;
            mem_mem_read   <= ex_valid & ex_mem_read;
            mem_mem_write  <= ex_valid & ex_mem_write & ~trap_c;
            mem_store_data <= ex_store_data;
        end
    end

    // Exception sequencer: one pulse per captured trapping instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ovf_exc <= 1'b0;
        end else begin
            ovf_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture_c && trap_c) begin
                        state   <= SENT;
                        ovf_exc <= 1'b1;
                    end
                end
                SENT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (capture_c) begin
                        if (trap_c) begin
                            ovf_exc <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Randomized scoreboard bench for ex_mem_stage_reg with an arithmetic model.
module tb_ex_mem_stage_reg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RA_W  = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ex_valid, ex_c_msb, ex_cout, ex_sub, ex_trap_ovf;
    logic [WIDTH-1:0] ex_sum, ex_store_data;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_reg_write, ex_mem_read, ex_mem_write;
    logic             stall, flush;
    logic             mem_valid, mem_zero, mem_ovf, mem_borrow;
    logic [WIDTH-1:0] mem_alu_result, mem_store_data;
    logic [RA_W-1:0]  mem_rd;
    logic             mem_reg_write, mem_mem_read, mem_mem_write, ovf_exc;

    ex_mem_stage_reg #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_sum(ex_sum),
        .ex_c_msb(ex_c_msb), .ex_cout(ex_cout), .ex_sub(ex_sub),
        .ex_trap_ovf(ex_trap_ovf), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
        .mem_zero(mem_zero), .mem_ovf(mem_ovf), .mem_borrow(mem_borrow),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_store_data(mem_store_data), .ovf_exc(ovf_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic             data_known;
        logic [WIDTH-1:0] alu;
        logic             zero, ovf, borrow;
        logic [RA_W-1:0]  rd;
        logic             rw, mr, mw;
        logic [WIDTH-1:0] sd;
        logic             exc;
    } exp_t;

    exp_t model;
    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        else
            n_pass++;
    endtask

    task automatic check_outputs(input exp_t e);
        chk("valid", WIDTH'(mem_valid), WIDTH'(e.valid));
        chk("zero", WIDTH'(mem_zero), WIDTH'(e.zero));
        chk("ovf", WIDTH'(mem_ovf), WIDTH'(e.ovf));
        chk("borrow", WIDTH'(mem_borrow), WIDTH'(e.borrow));
        chk("rd", WIDTH'(mem_rd), WIDTH'(e.rd));
        chk("reg_write", WIDTH'(mem_reg_write), WIDTH'(e.rw));
        chk("mem_read", WIDTH'(mem_mem_read), WIDTH'(e.mr));
        chk("mem_write", WIDTH'(mem_mem_write), WIDTH'(e.mw));
        chk("ovf_exc", WIDTH'(ovf_exc), WIDTH'(e.exc));
        if (e.data_known) begin
            chk("alu_result", mem_alu_result, e.alu);
            chk("store_data", mem_store_data, e.sd);
        end
    endtask

    function automatic exp_t reset_model();
        exp_t e;
        e = '{valid: 1'b0, data_known: 1'b1, alu: '0, zero: 1'b0, ovf: 1'b0,
              borrow: 1'b0, rd: '0, rw: 1'b0, mr: 1'b0, mw: 1'b0, sd: '0, exc: 1'b0};
        return e;
    endfunction

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) check_outputs(exp_q.pop_front());
    end

    // One EX instruction a op b; chain outputs and expectations from plain arithmetic.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic trap, input logic valid, input logic [RA_W-1:0] rd,
                        input logic rw, input logic mr, input logic mw,
                        input logic [31:0] sd, input logic st, input logic fl);
        logic [31:0] bb, lo, sum;
        logic [32:0] full;
        longint      sa, sb, res;
        logic        sgn_ovf, trapv;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 33'(sub);
        lo   = {1'b0, a[30:0]} + {1'b0, bb[30:0]} + 32'(sub);
        sum  = full[31:0];
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        res  = sub ? sa - sb : sa + sb;
        sgn_ovf = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        trapv   = valid && trap && sgn_ovf;
        @(negedge clk);
        ex_valid = valid; ex_sum = sum; ex_c_msb = lo[31]; ex_cout = full[32];
        ex_sub = sub; ex_trap_ovf = trap; ex_rd = rd; ex_reg_write = rw;
        ex_mem_read = mr; ex_mem_write = mw; ex_store_data = sd;
        stall = st; flush = fl;
        @(posedge clk);
        if (fl) begin
            model.valid = 1'b0; model.zero = 1'b0; model.ovf = 1'b0;
            model.borrow = 1'b0; model.rd = '0; model.rw = 1'b0;
            model.mr = 1'b0; model.mw = 1'b0; model.exc = 1'b0;
        end else if (st) begin
            model.exc = 1'b0;
        end else begin
            model.valid = valid;
            model.data_known = valid;
            model.alu = sum;
            model.sd = sd;
            model.zero = valid && (sum == 32'd0);
            model.ovf = valid && sgn_ovf;
            model.borrow = valid && sub && (a < b);
            model.rd = rd;
            model.rw = valid && rw && !trapv;
            model.mr = valid && mr;
            model.mw = valid && mw && !trapv;
            model.exc = trapv;
        end
        exp_q.push_back(model);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 0; ex_sum = '0; ex_c_msb = 0; ex_cout = 0; ex_sub = 0;
        ex_trap_ovf = 0; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
        ex_mem_write = 0; ex_store_data = '0; stall = 0; flush = 0;
        model = reset_model();
        #12;
        check_outputs(model);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        step(32'd5, 32'd3, 0, 1, 1, 5'd9, 1, 0, 0, 32'h0, 0, 0);
        step(32'h7FFF_FFFF, 32'd1, 0, 1, 1, 5'd10, 1, 0, 0, 32'h0, 0, 0);
        step(32'd1, 32'd1, 0, 1, 1, 5'd11, 1, 0, 0, 32'h0, 0, 0);
        step(32'h7FFF_FFFF, 32'd1, 0, 0, 1, 5'd12, 1, 0, 0, 32'h0, 0, 0);
        step(32'd5, 32'd5, 1, 1, 1, 5'd13, 1, 0, 0, 32'h0, 0, 0);
        step(32'd3, 32'd5, 1, 1, 1, 5'd14, 1, 0, 0, 32'h0, 0, 0);
        step(32'h7FFF_FFFF, 32'd1, 0, 1, 1, 5'd15, 1, 0, 1, 32'hDEAD_BEEF, 0, 0);
        for (int i = 0; i < 3; i++)
            step($urandom, $urandom, 0, 1, 1, 5'(i), 1, 1, 1, $urandom, 1, 0);
        step(32'd20, 32'd22, 0, 1, 1, 5'd16, 1, 0, 0, 32'h0, 0, 0);
        step(32'd100, 32'd4, 0, 0, 1, 5'd17, 0, 0, 1, 32'h1234_5678, 1, 1);
        step(32'h8000_0000, 32'h8000_0000, 0, 1, 1, 5'd18, 1, 1, 0, 32'h0, 0, 1);

        // Asynchronous reset while a trapping instruction is pulsing.
        step(32'h7FFF_FFFF, 32'd1, 0, 1, 1, 5'd19, 1, 1, 1, 32'hCAFE_F00D, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model = reset_model();
        check_outputs(model);
        exp_q.push_back(model);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(32'd5, 32'd3, 0, 1, 1, 5'd9, 1, 0, 0, 32'h55, 0, 0);

        // Randomized traffic with biased overflow and equal operands.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], {31{~a[31]}}};
            step(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 8, 5'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_reg.md
# ex_mem_stage_reg

EX/MEM pipeline register directly downstream of the ripple-carry add/subtract chain built from the 1-bit full-adder/subtractor cells. Each cycle it captures the 32-bit sum, the carry into and out of the MSB cell, and the instruction's control fields. It derives the zero, overflow and borrow flags and gates the register/memory writes of trapping overflows. It supports stall (hold) and flush (bubble) from the hazard unit and emits a one-shot overflow exception pulse.

## Interface
- WIDTH, 32, datapath width; the adder chain is WIDTH cells
- RA_W, 5, register-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_sum  in  WIDTH  S outputs of the adder chain, bit 0 = LSB cell
- ex_c_msb  in  1  carry into cell WIDTH-1
- ex_cout  in  1  Cout of cell WIDTH-1
- ex_sub  in  1  chain performed subtraction (Ya inverted, Cin=1)
- ex_trap_ovf  in  1  signed op that traps on overflow (add/sub/addi, not addu/subu)
- ex_rd  in  RA_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- ex_store_data  in  WIDTH  rt value for stores
- stall  in  1  hold the register contents
- flush  in  1  replace the captured instruction with a bubble
- mem_valid  out  1
- mem_alu_result  out  WIDTH
- mem_zero, mem_ovf, mem_borrow  out  1 each  flags
- mem_rd  out  RA_W
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each
- mem_store_data  out  WIDTH
- ovf_exc  out  1  single-cycle overflow exception pulse

## Operation
- Flag derivation, combinational from EX inputs, registered with the data:
  - ovf = ex_c_msb XOR ex_cout
  - zero = (ex_sum == 0)
  - borrow = ex_sub AND NOT ex_cout, the unsigned a<b result for sub/sltu
- Write gating:
  - trap = ex_valid AND ex_trap_ovf AND ovf.
  - On trap: capture mem_reg_write=0 and mem_mem_write=0. mem_alu_result, mem_ovf=1 and mem_valid=1 are still captured so the exception path sees the instruction.
  - mem_mem_read is captured unchanged.
- Without trap, control bits are captured as given.
- When ex_valid=0, all control bits and flags are captured as 0. Data buses are captured but don't-care.
- Capture priority each rising edge, highest first:
  1. flush=1: bubble. mem_valid, the control bits, the flags and mem_rd all go to 0. Data buses keep their old values.
  2. stall=1: every output register holds.
  3. Otherwise: capture EX values.
- ovf_exc sequencing, 2-state FSM:
  - States are IDLE and SENT.
  - IDLE -> SENT on a capture edge with trap=1. ovf_exc=1 for exactly the following cycle.
  - SENT -> IDLE on the next capture edge or flush. SENT holds while stall=1. ovf_exc=0 in SENT, so a stalled trapping instruction pulses once only.
  - If a capture edge with trap=1 occurs while in SENT, ovf_exc re-asserts for the new instruction. Each trapping instruction produces exactly one pulse.
  - Flush in IDLE stays in IDLE. A trap at the same edge as flush is discarded: no pulse.

## Timing
- Latency: 1 cycle, EX inputs to mem_* outputs.
- ovf_exc is registered and asserted in the first cycle the trapping instruction is visible on mem_*.
- Reset (rst_n=0, asynchronous, any time): all outputs go to 0, including data buses, and the FSM goes to IDLE.
  - Reset in the middle of a stall or of an ovf_exc pulse drops everything immediately.
  - The first capture after deassertion is the first rising edge with rst_n=1.
- flush and stall asserted together: flush wins.
- There is no combinational path from any input to any output.

## Test plan
- Reset, then 0x0000_0005 + 0x0000_0003 (ex_sum=0x8, c_msb=0, cout=0, reg_write=1, rd=9) -> next cycle: mem_alu_result=0x8, mem_rd=9, mem_reg_write=1, all flags 0, ovf_exc=0.
- add 0x7FFF_FFFF + 1 with ex_trap_ovf=1 (sum=0x8000_0000, c_msb=1, cout=0, reg_write=1) -> mem_ovf=1, mem_reg_write=0, mem_valid=1. ovf_exc=1 for one cycle only. Repeat with ex_trap_ovf=0 (addu) -> mem_reg_write=1, ovf_exc never asserted.
- sub 5 - 5 (ex_sub=1, sum=0, cout=1) -> mem_zero=1, mem_borrow=0. sub 3 - 5 (sum=0xFFFF_FFFE, cout=0) -> mem_borrow=1, mem_zero=0.
- Trapping overflow captured, then stall held for 3 cycles -> outputs stable for all 3 cycles, ovf_exc high only in the first cycle. Deassert stall with a normal add in EX -> normal capture, no pulse.
- flush and stall both high with a valid store in EX (mem_write=1) -> next cycle mem_valid=0, mem_mem_write=0, mem_rd=0, ovf_exc=0.
- Pull rst_n low mid-cycle while mem_valid=1 and ovf_exc=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first edge captures normally.
